// File: rtl/bin_to_bcd_dabble_if.sv
// Conversion request/response bundle for bin_to_bcd_dabble.
// Handshake: enable is taken only while busy=0 (one start per sampled cycle); out_dataV is a one-cycle pulse, output_bcd holds until the next result.
interface bin_to_bcd_dabble_if #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
);
  logic [IN_W-1:0]     input_number;
  logic                enable;
  logic [4*DIGITS-1:0] output_bcd;
  logic                out_dataV;
  logic                busy;

  modport master (
    output input_number,
    output enable,
    input  output_bcd,
    input  out_dataV,
    input  busy
  );

  modport slave (
    input  input_number,
    input  enable,
    output output_bcd,
    output out_dataV,
    output busy
  );
endinterface

// File: rtl/bin_to_bcd_dabble.sv
// Iterative double-dabble binary-to-BCD converter: one ADJUST and one SHIFT cycle per input bit.
// A result appears 2*IN_W+1 edges after the start is sampled.
module bin_to_bcd_dabble #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bin_to_bcd_dabble_if.slave  bus,
  output logic [1:0]          state_dbg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  // Largest input must fit in DIGITS decimal digits: 10^DIGITS > 2^IN_W.
  function automatic bit params_ok(input int in_w, input int digits);
    logic [255:0] p10;
    logic [255:0] p2;
    p10 = 256'd1;
    for (int i = 0; i < digits; i++) p10 = p10 * 256'd10;
    p2 = 256'd1 << in_w;
    return (p10 > p2);
  endfunction

  localparam bit PARAMS_OK = params_ok(IN_W, DIGITS);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("bin_to_bcd_dabble: DIGITS too small for IN_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [IN_W-1:0]    bin_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [BCD_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.enable) state_n = ADJUST;
      ADJUST:  state_n = SHIFT;
      SHIFT:   state_n = (cnt_q == CNT_W'(1)) ? DONE : ADJUST;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Add-3 per digit keeps every digit at <= 9 once it is doubled by the next shift.
  always_comb begin
    scratch_adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) scratch_adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            bin_q     <= bus.input_number;
            scratch_q <= '0;
            cnt_q     <= CNT_W'(IN_W);
          end
        end
        ADJUST: scratch_q <= scratch_adj;
        SHIFT: begin
          {scratch_q, bin_q} <= {scratch_q[BCD_W-2:0], bin_q, 1'b0};
          cnt_q              <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          bcd_q   <= scratch_q;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.output_bcd = bcd_q;
  assign bus.out_dataV  = valid_q;
  assign bus.busy       = (state != IDLE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_bin_to_bcd_dabble.sv
// Bench for bin_to_bcd_dabble: directed corner cases plus random conversions,
// checked by a monitor against an arithmetic decimal-digit model.
module tb_bin_to_bcd_dabble;
  localparam int IN_W   = 12;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int LAT    = 2 * IN_W + 1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin_to_bcd_dabble_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();
  logic [1:0] state_dbg;

  bin_to_bcd_dabble #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic         prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Decimal digits by plain division.
  function automatic logic [W-1:0] ref_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.out_dataV === 1'b1) begin
      check("valid_not_consecutive", {31'd0, prev_v}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("output_bcd", {16'd0, bus.output_bcd}, {16'd0, exp_q.pop_front()});
        check("latency_edge", cyc, exp_cyc_q.pop_front());
      end
    end
    if (rst_n) begin
      if (exp_q.size() != 0) check("busy", {31'd0, bus.busy}, {31'd0, (cyc < exp_cyc_q[0])});
      else                   check("busy_idle", {31'd0, bus.busy}, 32'd0);
    end
    prev_v <= bus.out_dataV;
  end

  // driver tasks
  task automatic start(input int v, input bit expect_accept);
    logic [31:0] scramble;
    bus.input_number = v[IN_W-1:0];
    bus.enable       = 1'b1;
    @(posedge clk);
    #1;
    if (expect_accept) begin
      exp_q.push_back(ref_bcd(v));
      exp_cyc_q.push_back(cyc + LAT);
    end
    bus.enable       = 1'b0;
    scramble         = $urandom;
    bus.input_number = scramble[IN_W-1:0];
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (bus.out_dataV !== 1'b1 && n < 100);
    check("wait_valid_timeout", {31'd0, bus.out_dataV}, 32'd1);
  endtask

  initial begin
    int v;
    int gap;
    bus.enable       = 1'b0;
    bus.input_number = '0;
    rst_n            = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_output_bcd", {16'd0, bus.output_bcd}, 32'd0);
    check("rst_out_dataV", {31'd0, bus.out_dataV}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;

    // first edge after release accepts; zero conversion
    start(0, 1'b1);
    drain();

    start(4095, 1'b1); drain();
    start(255, 1'b1);  drain();
    start(1000, 1'b1); drain();
    start(999, 1'b1);  drain();

    // enable while busy is ignored
    start(123, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start(456, 1'b0);
    drain();
    repeat (5) @(negedge clk);
    check("output_hold", {16'd0, bus.output_bcd}, {16'd0, ref_bcd(123)});

    // reset mid-conversion
    start(4095, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    exp_q.delete();
    exp_cyc_q.delete();
    rst_n = 1'b0;
    #1;
    check("midrst_output_bcd", {16'd0, bus.output_bcd}, 32'd0);
    check("midrst_out_dataV", {31'd0, bus.out_dataV}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_output_bcd", {16'd0, bus.output_bcd}, 32'd0);
    start(42, 1'b1);
    drain();

    // back-to-back: new start in the valid cycle
    start(77, 1'b1);
    wait_valid();
    start(88, 1'b1);
    drain();

    // random conversions, mixing gaps and back-to-back starts
    repeat (25) begin
      v   = $urandom_range(0, (1 << IN_W) - 1);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      start(v, 1'b1);
      if ($urandom_range(0, 1) == 0) drain();
      else                           wait_valid();
    end
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_dabble.md
BIN_TO_BCD_DABBLE -- requirements
Module: bin_to_bcd_dabble

Interface
REQ-001 Parameter IN_W SHALL be declared: default 12, binary input width in bits.
REQ-002 Parameter DIGITS SHALL be declared: default 4, number of 4-bit BCD output digits.
REQ-003 The parameter pair SHALL satisfy 10^DIGITS > 2^IN_W; any other pair SHALL be rejected at elaboration.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 input_number  input  IN_W  SHALL carry the unsigned binary value to convert.
REQ-007 enable  input  1  SHALL be the start strobe; input_number is sampled when it is high in IDLE.
REQ-008 output_bcd  output  4*DIGITS  SHALL carry the packed BCD result, most significant digit in the top nibble.
REQ-009 out_dataV  output  1  SHALL be a one-cycle pulse marking output_bcd as newly valid.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-011 The block SHALL be an iterative double-dabble (shift-add-3) converter built on a state machine with states IDLE, ADJUST, SHIFT and DONE.
REQ-012 In IDLE with enable=1, the block SHALL latch input_number into a shift register, clear the BCD scratch register, load the iteration counter with IN_W and go to ADJUST.
REQ-013 In IDLE with enable=0, the block SHALL hold all state.
REQ-014 In ADJUST, the block SHALL add 3 to every scratch digit >= 5, leave digits <= 4 unchanged, and go to SHIFT.
REQ-015 In SHIFT, the block SHALL shift the concatenation {scratch, binary} left by one bit with a 0 entering the LSB, and decrement the counter.
REQ-016 SHIFT SHALL go to DONE when the counter reaches 0, and to ADJUST otherwise.
REQ-017 In DONE, the block SHALL register the scratch into output_bcd, set out_dataV=1 for exactly one cycle, and return to IDLE.
REQ-018 Latency: if enable is sampled at edge N, out_dataV SHALL be high in the cycle following edge N+2*IN_W+1 (after edge 25 for the defaults).
REQ-019 All adjust and shift arithmetic SHALL be confined to the 4-bit digit fields; no scratch digit SHALL exceed 9 after any SHIFT.
REQ-020 enable SHALL be ignored while busy=1; the conversion in flight SHALL be unaffected.
REQ-021 A change on input_number after the sampling edge SHALL NOT affect the result.
REQ-022 enable high in the same cycle that out_dataV is high (state IDLE) SHALL be accepted as a new conversion, giving back-to-back operation.
REQ-023 output_bcd SHALL hold its last value until the next DONE.
REQ-024 out_dataV SHALL never be high for two consecutive cycles.

Reset
REQ-025 While rst_n=0, the block SHALL force: state to IDLE; output_bcd, scratch, shift register and counter to 0; out_dataV and busy to 0.
REQ-026 A reset asserted mid-conversion SHALL abort that conversion without any out_dataV pulse.
REQ-027 After rst_n is released, the first rising edge SHALL be able to accept enable.

Verification
REQ-028 The bench SHALL cover:
- Conversion of 0: input_number=12'd0, enable pulse -> output_bcd=16'h0000, one out_dataV pulse, 25 edges after the sampling edge.
- Full scale: input_number=12'd4095 -> output_bcd=16'h4095.
- Digit-boundary values: inputs 255, 1000 and 999 -> 16'h0255, 16'h1000 and 16'h0999 respectively.
- Busy interlock: start with 123; pulse enable with 456 at edge 5 -> result 16'h0123, busy high throughout, exactly one out_dataV pulse.
- Reset mid-operation: start with 4095; drive rst_n low at edge 10 -> all outputs 0, no out_dataV; a new start with 42 then yields 16'h0042.
- Back-to-back: start 77; assert enable with 88 in the out_dataV cycle -> 16'h0077, then 16'h0088 exactly 26 edges later.
